// File: rtl/algo_4r4w_a99_rd_resp_buf.sv
// Per-port read-response buffer for the 4r4w core: four first-word-fall-through FIFOs
// with credit-based issue throttling, sticky overflow/illegal-issue flags and ECC counters.
module algo_4r4w_a99_rd_resp_buf #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BITPADR = 15,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BITDPTH = 3,
  parameter int unsigned CNTWDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             rd_issue,
  output logic [3:0]             rd_allow,
  input  logic [3:0]             rd_vld,
  input  logic [4*WIDTH-1:0]     rd_dout,
  input  logic [3:0]             rd_serr,
  input  logic [3:0]             rd_derr,
  input  logic [4*BITPADR-1:0]   rd_padr,
  input  logic [3:0]             out_pop,
  output logic [3:0]             out_vld,
  output logic [4*WIDTH-1:0]     out_dout,
  output logic [3:0]             out_serr,
  output logic [3:0]             out_derr,
  output logic [4*BITPADR-1:0]   out_padr,
  output logic [3:0]             ovf_err,
  output logic [3:0]             iss_err,
  output logic [4*CNTWDTH-1:0]   serr_cnt,
  output logic [4*CNTWDTH-1:0]   derr_cnt,
  input  logic                   clr_stat
);

  localparam int unsigned NP = 4;
  localparam int unsigned EW = WIDTH + BITPADR + 2;
  localparam int unsigned OW = BITDPTH + 1;
  localparam int unsigned SW = BITDPTH + 2;

  // Entry layout: {dout, serr, derr, padr}
  logic [EW-1:0]      mem     [NP][DEPTH];
  logic [EW-1:0]      in_ent  [NP];
  logic [EW-1:0]      head_q  [NP];
  logic [EW-1:0]      head_d  [NP];
  logic [BITDPTH-1:0] wptr_q  [NP];
  logic [BITDPTH-1:0] wptr_d  [NP];
  logic [BITDPTH-1:0] rptr_q  [NP];
  logic [BITDPTH-1:0] rptr_d  [NP];
  logic [OW-1:0]      occ_q   [NP];
  logic [OW-1:0]      occ_d   [NP];
  logic [OW-1:0]      inf_q   [NP];
  logic [OW-1:0]      inf_d   [NP];
  logic [CNTWDTH-1:0] scnt_q  [NP];
  logic [CNTWDTH-1:0] scnt_d  [NP];
  logic [CNTWDTH-1:0] dcnt_q  [NP];
  logic [CNTWDTH-1:0] dcnt_d  [NP];

  logic [NP-1:0] vld_q, vld_d, allow_q, allow_d;
  logic [NP-1:0] ovf_q, ovf_d, iss_q, iss_d;
  logic [NP-1:0] push, pop, inc, dec;

  // Next-state computation for all four ports
  always_comb begin
    in_ent  = '{default: '0};
    head_d  = '{default: '0};
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    occ_d   = occ_q;
    inf_d   = inf_q;
    scnt_d  = scnt_q;
    dcnt_d  = dcnt_q;
    vld_d   = vld_q;
    allow_d = allow_q;
    ovf_d   = ovf_q;
    iss_d   = iss_q;
    push    = '0;
    pop     = '0;
    inc     = '0;
    dec     = '0;
    for (int p = 0; p < NP; p++) begin
      in_ent[p] = {rd_dout[p*WIDTH +: WIDTH], rd_serr[p], rd_derr[p],
                   rd_padr[p*BITPADR +: BITPADR]};
      pop[p]  = out_pop[p] & vld_q[p];
      // A full FIFO still accepts a push when the same edge pops it
      push[p] = rd_vld[p] & ((occ_q[p] != OW'(DEPTH)) | pop[p]);

      if (push[p]) wptr_d[p] = BITDPTH'(wptr_q[p] + 1'b1);
      if (pop[p])  rptr_d[p] = BITDPTH'(rptr_q[p] + 1'b1);

      case ({push[p], pop[p]})
        2'b10:   occ_d[p] = OW'(occ_q[p] + 1'b1);
        2'b01:   occ_d[p] = OW'(occ_q[p] - 1'b1);
        default: occ_d[p] = occ_q[p];
      endcase

      inc[p] = rd_issue[p] & allow_q[p];
      dec[p] = rd_vld[p] & (inf_q[p] != '0);
      case ({inc[p], dec[p]})
        2'b10:   inf_d[p] = OW'(inf_q[p] + 1'b1);
        2'b01:   inf_d[p] = OW'(inf_q[p] - 1'b1);
        default: inf_d[p] = inf_q[p];
      endcase

      allow_d[p] = (SW'(occ_d[p]) + SW'(inf_d[p])) < SW'(DEPTH);
      vld_d[p]   = (occ_d[p] != '0);

      // Head register tracks the entry at the next read pointer
      if (occ_d[p] == '0)
        head_d[p] = '0;
      else if (push[p] && (wptr_q[p] == rptr_d[p]))
        head_d[p] = in_ent[p];
      else
        head_d[p] = mem[p][rptr_d[p]];

      if (clr_stat) begin
        ovf_d[p]  = 1'b0;
        iss_d[p]  = 1'b0;
        scnt_d[p] = '0;
        dcnt_d[p] = '0;
      end else begin
        if (rd_vld[p] && !push[p])  ovf_d[p] = 1'b1;
        if (rd_issue[p] && !allow_q[p]) iss_d[p] = 1'b1;
        if (push[p] && rd_serr[p] && (scnt_q[p] != '1))
          scnt_d[p] = CNTWDTH'(scnt_q[p] + 1'b1);
        if (push[p] && rd_derr[p] && (dcnt_q[p] != '1))
          dcnt_d[p] = CNTWDTH'(dcnt_q[p] + 1'b1);
      end
    end
  end

  // Control and status state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        head_q[p] <= '0;
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        occ_q[p]  <= '0;
        inf_q[p]  <= '0;
        scnt_q[p] <= '0;
        dcnt_q[p] <= '0;
      end
      vld_q   <= '0;
      allow_q <= '1;
      ovf_q   <= '0;
      iss_q   <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        head_q[p] <= head_d[p];
        wptr_q[p] <= wptr_d[p];
        rptr_q[p] <= rptr_d[p];
        occ_q[p]  <= occ_d[p];
        inf_q[p]  <= inf_d[p];
        scnt_q[p] <= scnt_d[p];
        dcnt_q[p] <= dcnt_d[p];
      end
      vld_q   <= vld_d;
      allow_q <= allow_d;
      ovf_q   <= ovf_d;
      iss_q   <= iss_d;
    end
  end

  // Storage array; contents are only observable through the head register
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem[p][wptr_q[p]] <= in_ent[p];
    end
  end

  always_comb begin
    out_dout = '0;
    out_serr = '0;
    out_derr = '0;
    out_padr = '0;
    serr_cnt = '0;
    derr_cnt = '0;
    for (int p = 0; p < NP; p++) begin
      out_dout[p*WIDTH +: WIDTH]     = head_q[p][EW-1 -: WIDTH];
      out_serr[p]                    = head_q[p][BITPADR+1];
      out_derr[p]                    = head_q[p][BITPADR];
      out_padr[p*BITPADR +: BITPADR] = head_q[p][BITPADR-1:0];
      serr_cnt[p*CNTWDTH +: CNTWDTH] = scnt_q[p];
      derr_cnt[p*CNTWDTH +: CNTWDTH] = dcnt_q[p];
    end
  end

  assign rd_allow = allow_q;
  assign out_vld  = vld_q;
  assign ovf_err  = ovf_q;
  assign iss_err  = iss_q;

endmodule

// File: tb/tb_algo_4r4w_a99_rd_resp_buf.sv
// Bench for algo_4r4w_a99_rd_resp_buf: directed scenarios then random traffic,
// all checked against a queue-based model; a second instance uses 2-bit counters.
module tb_algo_4r4w_a99_rd_resp_buf;

  localparam int W  = 32;
  localparam int PA = 15;
  localparam int D  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]      issue = '0, vld = '0, serr = '0, derr = '0, pop = '0;
  logic [4*W-1:0]  dout = '0;
  logic [4*PA-1:0] padr = '0;
  logic            clr = 1'b0;

  logic [3:0]      rd_allow, out_vld, out_serr, out_derr, ovf_err, iss_err;
  logic [4*W-1:0]  out_dout;
  logic [4*PA-1:0] out_padr;
  logic [4*CW-1:0] serr_cnt, derr_cnt;

  logic [3:0]      rd_allow2, out_vld2, out_serr2, out_derr2, ovf2, iss2;
  logic [4*W-1:0]  out_dout2;
  logic [4*PA-1:0] out_padr2;
  logic [7:0]      serr_cnt2, derr_cnt2;

  algo_4r4w_a99_rd_resp_buf dut (
    .clk(clk), .rst(rst), .rd_issue(issue), .rd_allow(rd_allow), .rd_vld(vld),
    .rd_dout(dout), .rd_serr(serr), .rd_derr(derr), .rd_padr(padr), .out_pop(pop),
    .out_vld(out_vld), .out_dout(out_dout), .out_serr(out_serr), .out_derr(out_derr),
    .out_padr(out_padr), .ovf_err(ovf_err), .iss_err(iss_err), .serr_cnt(serr_cnt),
    .derr_cnt(derr_cnt), .clr_stat(clr)
  );

  algo_4r4w_a99_rd_resp_buf #(.CNTWDTH(2)) dut2 (
    .clk(clk), .rst(rst), .rd_issue(issue), .rd_allow(rd_allow2), .rd_vld(vld),
    .rd_dout(dout), .rd_serr(serr), .rd_derr(derr), .rd_padr(padr), .out_pop(pop),
    .out_vld(out_vld2), .out_dout(out_dout2), .out_serr(out_serr2), .out_derr(out_derr2),
    .out_padr(out_padr2), .ovf_err(ovf2), .iss_err(iss2), .serr_cnt(serr_cnt2),
    .derr_cnt(derr_cnt2), .clr_stat(clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          s;
    logic          e;
    logic [PA-1:0] a;
  } ent_t;

  ent_t mq[4][$];
  int   minf[4];
  int   msc[4], mdc[4], msc2[4], mdc2[4];
  logic [3:0] movf, miss;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      mq[p].delete();
      minf[p] = 0; msc[p] = 0; mdc[p] = 0; msc2[p] = 0; mdc2[p] = 0;
    end
    movf = '0;
    miss = '0;
  endtask

  // One clock edge of the behavioural model, using the inputs present at the edge
  task automatic model_step();
    for (int p = 0; p < 4; p++) begin
      int   occ;
      bit   allow, pk, acc;
      int   inc, dcr;
      ent_t en;
      occ   = mq[p].size();
      allow = (occ + minf[p]) < D;
      pk    = pop[p] && (occ > 0);
      acc   = vld[p] && ((occ < D) || pk);
      en    = '{d: dout[p*W +: W], s: serr[p], e: derr[p], a: padr[p*PA +: PA]};
      if (pk)  void'(mq[p].pop_front());
      if (acc) mq[p].push_back(en);
      inc = (issue[p] && allow) ? 1 : 0;
      dcr = (vld[p] && minf[p] > 0) ? 1 : 0;
      minf[p] = minf[p] + inc - dcr;
      if (clr) begin
        movf[p] = 1'b0; miss[p] = 1'b0;
        msc[p] = 0; mdc[p] = 0; msc2[p] = 0; mdc2[p] = 0;
      end else begin
        if (vld[p] && !acc)    movf[p] = 1'b1;
        if (issue[p] && !allow) miss[p] = 1'b1;
        if (acc && en.s) begin
          if (msc[p] < 65535) msc[p]++;
          if (msc2[p] < 3)    msc2[p]++;
        end
        if (acc && en.e) begin
          if (mdc[p] < 65535) mdc[p]++;
          if (mdc2[p] < 3)    mdc2[p]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag);
    logic [3:0]      e_vld, e_allow, e_s, e_e;
    logic [4*W-1:0]  e_d;
    logic [4*PA-1:0] e_a;
    logic [4*CW-1:0] e_sc, e_dc;
    logic [7:0]      e_sc2, e_dc2;
    e_vld = '0; e_allow = '0; e_s = '0; e_e = '0; e_d = '0; e_a = '0;
    e_sc = '0; e_dc = '0; e_sc2 = '0; e_dc2 = '0;
    for (int p = 0; p < 4; p++) begin
      e_allow[p] = (mq[p].size() + minf[p]) < D;
      if (mq[p].size() > 0) begin
        e_vld[p]         = 1'b1;
        e_d[p*W +: W]    = mq[p][0].d;
        e_s[p]           = mq[p][0].s;
        e_e[p]           = mq[p][0].e;
        e_a[p*PA +: PA]  = mq[p][0].a;
      end
      e_sc[p*CW +: CW] = CW'(msc[p]);
      e_dc[p*CW +: CW] = CW'(mdc[p]);
      e_sc2[p*2 +: 2]  = 2'(msc2[p]);
      e_dc2[p*2 +: 2]  = 2'(mdc2[p]);
    end
    check({tag, "/out_vld"},  out_vld,  e_vld);
    check({tag, "/rd_allow"}, rd_allow, e_allow);
    check({tag, "/head"},     {out_dout, out_padr, out_serr, out_derr}, {e_d, e_a, e_s, e_e});
    check({tag, "/flags"},    {ovf_err, iss_err}, {movf, miss});
    check({tag, "/cnts"},     {serr_cnt, derr_cnt}, {e_sc, e_dc});
    check({tag, "/dut2_ctl"}, {out_vld2, rd_allow2, ovf2, iss2}, {e_vld, e_allow, movf, miss});
    check({tag, "/dut2_head"}, {out_dout2, out_padr2, out_serr2, out_derr2}, {e_d, e_a, e_s, e_e});
    check({tag, "/dut2_cnts"}, {serr_cnt2, derr_cnt2}, {e_sc2, e_dc2});
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    chk(tag);
  endtask

  task automatic idle();
    issue = '0; vld = '0; serr = '0; derr = '0; pop = '0; clr = 1'b0;
  endtask

  task automatic set_rsp(input int p, input logic [W-1:0] d, input logic s, input logic e);
    vld[p] = 1'b1;
    dout[p*W +: W] = d;
    serr[p] = s;
    derr[p] = e;
    padr[p*PA +: PA] = PA'(d ^ 32'h5a5);
  endtask

  initial begin
    model_reset();
    repeat (2) cyc("reset");
    check("reset_allow", rd_allow, 4'hF);
    rst = 1'b0;

    // Port 0 credit exhaustion, illegal issue, return and one pop
    issue = 4'b0001;
    repeat (8) cyc("p0_issue");
    check("p0_allow_drop", rd_allow[0], 1'b0);
    cyc("p0_illegal_issue");
    check("p0_iss_err", iss_err[0], 1'b1);
    idle();
    for (int i = 0; i < 8; i++) begin
      set_rsp(0, 32'hA000 + 32'(i), 1'b0, 1'b0);
      cyc("p0_return");
    end
    idle();
    check("p0_full_allow", rd_allow[0], 1'b0);
    pop[0] = 1'b1;
    cyc("p0_pop1");
    check("p0_allow_back", rd_allow[0], 1'b1);
    repeat (7) cyc("p0_drain");
    idle();

    // Port 1 overflow, then push+pop while full
    for (int i = 0; i < 8; i++) begin
      set_rsp(1, 32'h100 + 32'(i), 1'b0, 1'b0);
      cyc("p1_fill");
    end
    set_rsp(1, 32'hDEAD, 1'b0, 1'b0);
    cyc("p1_overflow");
    check("p1_ovf", ovf_err[1], 1'b1);
    check("p1_head_kept", out_dout[63:32], 32'h100);
    idle();
    clr = 1'b1;
    cyc("p1_clr");
    idle();
    set_rsp(1, 32'hBEEF, 1'b0, 1'b0);
    pop[1] = 1'b1;
    cyc("p1_push_pop_full");
    check("p1_no_ovf", ovf_err[1], 1'b0);
    idle();
    pop[1] = 1'b1;
    repeat (8) cyc("p1_drain");
    idle();

    // Port 2 ordering and pointer wrap
    for (int i = 1; i <= 3; i++) begin
      set_rsp(2, 32'(i), 1'b0, 1'b0);
      cyc("p2_push");
    end
    idle();
    check("p2_head1", out_dout[95:64], 32'h1);
    pop[2] = 1'b1;
    cyc("p2_pop");
    check("p2_head2", out_dout[95:64], 32'h2);
    cyc("p2_pop");
    check("p2_head3", out_dout[95:64], 32'h3);
    cyc("p2_pop");
    idle();
    set_rsp(2, 32'h10, 1'b0, 1'b0);
    cyc("p2_seed");
    for (int i = 1; i <= 20; i++) begin
      set_rsp(2, 32'h10 + 32'(i), 1'b0, 1'b0);
      pop[2] = 1'b1;
      cyc("p2_wrap");
    end
    idle();
    check("p2_wrap_head", out_dout[95:64], 32'h24);
    pop[2] = 1'b1;
    cyc("p2_last");
    idle();

    // Port 3 ECC counters, clear, saturation of the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      set_rsp(3, 32'h300 + 32'(i), (i < 3) ? 1'b1 : 1'b0, (i >= 3) ? 1'b1 : 1'b0);
      pop[3] = 1'b1;
      cyc("p3_ecc");
    end
    idle();
    check("p3_serr3", serr_cnt[63:48], 16'd3);
    check("p3_derr2", derr_cnt[63:48], 16'd2);
    clr = 1'b1;
    pop[3] = 1'b1;
    cyc("p3_clr");
    check("p3_clr_zero", {serr_cnt[63:48], derr_cnt[63:48]}, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) begin
      set_rsp(3, 32'h380 + 32'(i), 1'b1, 1'b0);
      pop[3] = 1'b1;
      cyc("p3_sat");
    end
    idle();
    check("p3_sat_narrow", serr_cnt2[7:6], 2'd3);
    check("p3_wide_5", serr_cnt[63:48], 16'd5);
    pop[3] = 1'b1;
    cyc("p3_drain");
    idle();

    // Asynchronous reset with four entries buffered
    for (int i = 0; i < 4; i++) begin
      set_rsp(0, 32'h400 + 32'(i), 1'b1, 1'b0);
      cyc("rst_fill");
    end
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async");
    check("rst_async_vld", out_vld, 4'h0);
    check("rst_async_allow", rd_allow, 4'hF);
    cyc("rst_hold");
    rst = 1'b0;
    set_rsp(0, 32'h500, 1'b0, 1'b1);
    cyc("post_rst_vld");
    idle();

    // Random traffic with occasional clears and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      issue = 4'($urandom);
      vld   = 4'($urandom);
      pop   = ((i % 100) < 50) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
      dout  = {$urandom, $urandom, $urandom, $urandom};
      padr  = 60'({$urandom, $urandom});
      serr  = 4'($urandom & $urandom);
      derr  = 4'($urandom & $urandom);
      clr   = ($urandom_range(0, 29) == 0);
      rst   = (i == 200);
      cyc("rand");
    end
    rst = 1'b0;
    idle();
    cyc("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
